// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   - state encoding for the multiplier FSM
//   - two's-complement magnitude helper used when capturing signed operands
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX
  } state_t;

  // Widest operand the magnitude helper handles; callers sign-extend into it
  // and cast the result back down to their own width.
  localparam int MAG_MAX_W = 64;

  // Magnitude of a sign-extended two's-complement value. For the most
  // negative WIDTH-bit operand the result is 2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits once the caller truncates.
  function automatic logic [MAG_MAX_W-1:0] mag(input logic [MAG_MAX_W-1:0] x);
    return x[MAG_MAX_W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/add_n_bit.sv
// Parametrised ripple-carry adder, carry-in 0, carry-out dropped (modulo 2^N).
// Ports:
//   in1, in2 : N-bit addends
//   s        : N-bit sum
module add_n_bit #(
  parameter int N = 16
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] s
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = 1'b0;
    for (int i = 0; i < N; i++) begin
      s[i]  = in1[i] ^ in2[i] ^ carry;
      carry = (in1[i] & in2[i]) | (carry & (in1[i] ^ in2[i]));
    end
  end

endmodule

// File: rtl/mul_seq_n_bit.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned, one shared adder used over WIDTH+1 cycles.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands, sign and counter load on start
//   CALC  | one partial product per cycle, counter runs WIDTH down to 0
//   FIX   | apply sign (negate accumulator if needed), load mul, pulse done
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, aborts any operation
//   start      : request, only honoured in IDLE
//   is_signed  : 1 = two's-complement operands, captured with start
//   in1, in2   : multiplicand / multiplier, captured with start
//   busy       : high in CALC and FIX
//   done       : one-cycle pulse, mul valid in that cycle
//   mul        : product, held until the next operation completes
//
// WIDTH must be between 2 and MAG_MAX_W.
module mul_seq_n_bit
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mul
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic             neg;

  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] op1, op2;
  logic             neg_nx;

  logic [PW-1:0]    add_a, add_b, add_s;

  assign mag1   = WIDTH'(mag(MAG_MAX_W'({{MAG_MAX_W{in1[WIDTH-1]}}, in1})));
  assign mag2   = WIDTH'(mag(MAG_MAX_W'({{MAG_MAX_W{in2[WIDTH-1]}}, in2})));
  assign op1    = is_signed ? mag1 : in1;
  assign op2    = is_signed ? mag2 : in2;
  assign neg_nx = is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);

  // The single adder does the accumulate step in CALC and ~acc + 1 in FIX.
  always_comb begin
    add_a = acc;
    add_b = '0;
    if (state == FIX) begin
      add_a = ~acc;
      add_b = PW'(1);
    end else if (mplier[0]) begin
      add_b = mcand;
    end
  end

  add_n_bit #(
    .N (PW)
  ) u_add (
    .in1 (add_a),
    .in2 (add_b),
    .s   (add_s)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      mul    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, op1};
            mplier <= op2;
            acc    <= '0;
            neg    <= neg_nx;
            cnt    <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          acc    <= add_s;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
        end
        FIX: begin
          // Negating a zero accumulator wraps back to zero, so neg needs no
          // special case for zero operands.
          mul  <= neg ? add_s : acc;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_n_bit.sv
module tb_mul_seq_n_bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        st8, sg8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] mul8;
  logic        st16, sg16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] mul16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_seq_n_bit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .is_signed(sg8),
    .in1(a8), .in2(b8), .busy(busy8), .done(done8), .mul(mul8)
  );

  mul_seq_n_bit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .is_signed(sg16),
    .in1(a16), .in2(b16), .busy(busy16), .done(done16), .mul(mul16)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: interpret the operands as integers and multiply.
  function automatic longint ref_prod(input bit sgn, input longint a, input longint b, input int w);
    longint x, y;
    x = a;
    y = b;
    if (sgn) begin
      if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    end
    return x * y;
  endfunction

  // Issue one op on the 8-bit DUT; lat = edges from start edge to done cycle.
  task automatic run8(input bit sgn, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] m, output int lat, output int bcnt, output bit ok);
    m = '0; lat = 0; bcnt = 0; ok = 1'b0;
    @(negedge clk);
    st8 = 1'b1; sg8 = sgn; a8 = x; b8 = y;
    @(negedge clk);
    st8 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done8) begin
        ok = 1'b1; m = mul8;
        break;
      end
      if (busy8) bcnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic run16(input bit sgn, input logic [15:0] x, input logic [15:0] y,
                       output logic [31:0] m, output int lat, output int bcnt, output bit ok);
    m = '0; lat = 0; bcnt = 0; ok = 1'b0;
    @(negedge clk);
    st16 = 1'b1; sg16 = sgn; a16 = x; b16 = y;
    @(negedge clk);
    st16 = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done16) begin
        ok = 1'b1; m = mul16;
        break;
      end
      if (busy16) bcnt++;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      st8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      st16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
    end
    @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done8: got %b expected 0", done8); end
    n_cmp++; if (mul8 !== 16'h0) begin n_bad++; $display("FAIL reset_mul8: got %h expected 0000", mul8); end
    n_cmp++; if (busy16 !== 1'b0) begin n_bad++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
    n_cmp++; if (done16 !== 1'b0) begin n_bad++; $display("FAIL reset_done16: got %b expected 0", done16); end
    n_cmp++; if (mul16 !== 32'h0) begin n_bad++; $display("FAIL reset_mul16: got %h expected 0", mul16); end
    st8 = 1'b0; st16 = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [15:0] m; int lat, bc; bit ok;
    run8(1'b0, 8'd255, 8'd55, m, lat, bc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL u255x55_done: no done within bound"); end
    n_cmp++; if (m !== 16'h36C9) begin n_bad++; $display("FAIL u255x55_mul: got %h expected 36c9", m); end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL u255x55_latency: got %0d expected 9", lat); end
    n_cmp++; if (bc !== 9) begin n_bad++; $display("FAIL u255x55_busy_cycles: got %0d expected 9", bc); end
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL busy_in_done_cycle: got %b expected 0", busy8); end
    @(negedge clk);
    n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b expected 0", done8); end
    run8(1'b0, 8'hFF, 8'hFF, m, lat, bc, ok);
    n_cmp++; if (m !== 16'hFE01) begin n_bad++; $display("FAIL uFFxFF_mul: got %h expected fe01", m); end
  endtask

  task automatic test_signed();
    logic [15:0] m; int lat, bc; bit ok;
    run8(1'b1, 8'hFD, 8'd5, m, lat, bc, ok);
    n_cmp++; if (m !== 16'hFFF1) begin n_bad++; $display("FAIL s_m3x5_mul: got %h expected fff1", m); end
    run8(1'b1, 8'h80, 8'h80, m, lat, bc, ok);
    n_cmp++; if (m !== 16'h4000) begin n_bad++; $display("FAIL s_m128xm128_mul: got %h expected 4000", m); end
    run8(1'b1, 8'h00, 8'hFF, m, lat, bc, ok);
    n_cmp++; if (m !== 16'h0000) begin n_bad++; $display("FAIL s_0xm1_mul: got %h expected 0000", m); end
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL s_0xm1_latency: got %0d expected 9", lat); end
  endtask

  task automatic test_random();
    logic [15:0] m, exp; int lat, bc; bit ok, sgn; logic [7:0] x, y;
    for (int i = 0; i < 200; i++) begin
      sgn = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
      if (i % 16 == 0) x = 8'h80;
      if (i % 16 == 1) y = 8'h00;
      run8(sgn, x, y, m, lat, bc, ok);
      exp = 16'(ref_prod(sgn, longint'(x), longint'(y), 8));
      n_cmp++; if (!ok || m !== exp) begin n_bad++; $display("FAIL rand8 #%0d s=%0d %h*%h: got %h expected %h", i, sgn, x, y, m, exp); end
      n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL rand8_latency #%0d: got %0d expected 9", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int ndone, c_first, c_second; logic [15:0] m1, m2, held;
    ndone = 0; c_first = -1; c_second = -1; m1 = '0; m2 = '0; held = '0;
    @(negedge clk);
    st8 = 1'b1; sg8 = 1'b0; a8 = 8'd55; b8 = 8'd55;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      st8 = 1'b0;
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          c_first = c; m1 = mul8;
          st8 = 1'b1; a8 = 8'd2; b8 = 8'd4;
        end else if (ndone == 2) begin
          c_second = c; m2 = mul8;
        end
      end
      if (c == 3 || c == 13) begin st8 = 1'b1; a8 = 8'd9; b8 = 8'd9; end
      if (c_first >= 0 && c == c_first + 5) held = mul8;
      @(negedge clk);
    end
    n_cmp++; if (ndone !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    n_cmp++; if (c_first !== 9) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 9", c_first); end
    n_cmp++; if (m1 !== 16'd3025) begin n_bad++; $display("FAIL b2b_first_mul: got %0d expected 3025", m1); end
    n_cmp++; if (c_second - c_first !== 10) begin n_bad++; $display("FAIL b2b_spacing: got %0d expected 10", c_second - c_first); end
    n_cmp++; if (m2 !== 16'd8) begin n_bad++; $display("FAIL b2b_second_mul: got %0d expected 8", m2); end
    n_cmp++; if (held !== 16'd3025) begin n_bad++; $display("FAIL b2b_mul_held: got %0d expected 3025", held); end
  endtask

  task automatic test_reset_mid_op();
    int nd;
    @(negedge clk);
    st8 = 1'b1; sg8 = 1'b0; a8 = 8'd200; b8 = 8'd200;
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before: got %b expected 1", busy8); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done8); end
    n_cmp++; if (mul8 !== 16'h0) begin n_bad++; $display("FAIL midrst_mul: got %h expected 0000", mul8); end
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (done8) nd++;
      @(negedge clk);
    end
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d dones expected 0", nd); end
  endtask

  task automatic test_rst_with_start();
    logic [15:0] m; int lat, bc, nb, nd; bit ok;
    run8(1'b0, 8'd7, 8'd6, m, lat, bc, ok);
    n_cmp++; if (m !== 16'd42) begin n_bad++; $display("FAIL pre_rst_mul: got %0d expected 42", m); end
    @(negedge clk);
    rst = 1'b1; st8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    @(negedge clk);
    rst = 1'b0; st8 = 1'b0;
    n_cmp++; if (mul8 !== 16'h0) begin n_bad++; $display("FAIL rst_start_mul: got %h expected 0000", mul8); end
    nb = 0; nd = 0;
    for (int c = 0; c < 15; c++) begin
      if (busy8) nb++;
      if (done8) nd++;
      @(negedge clk);
    end
    n_cmp++; if (nb !== 0 || nd !== 0) begin n_bad++; $display("FAIL rst_start_ignored: got busy=%0d done=%0d expected 0/0", nb, nd); end
  endtask

  task automatic test_width16();
    logic [31:0] m, exp; int lat, bc; bit ok, sgn; logic [15:0] x, y;
    run16(1'b1, 16'h8000, 16'h7FFF, m, lat, bc, ok);
    n_cmp++; if (!ok || m !== 32'hC0008000) begin n_bad++; $display("FAIL w16_edge_mul: got %h expected c0008000", m); end
    n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL w16_latency: got %0d expected 17", lat); end
    n_cmp++; if (bc !== 17) begin n_bad++; $display("FAIL w16_busy_cycles: got %0d expected 17", bc); end
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
      run16(sgn, x, y, m, lat, bc, ok);
      exp = 32'(ref_prod(sgn, longint'(x), longint'(y), 16));
      n_cmp++; if (!ok || m !== exp) begin n_bad++; $display("FAIL rand16 #%0d s=%0d %h*%h: got %h expected %h", i, sgn, x, y, m, exp); end
    end
  endtask

  initial begin
    rst = 1'b1;
    st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    st16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_rst_with_start();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_seq_n_bit.md
Name: mul_seq_n_bit

Overview:
Parametrised, sequential shift-add multiplier; generalises the combinational 8-bit multiplier to any WIDTH. Adds a signed/unsigned mode and a start/busy/done handshake. Uses one adder over WIDTH cycles instead of a full array, so it suits area-constrained datapaths (SAD/accumulate paths next to the 16-bit adders).

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when the FSM is in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
in1  input  WIDTH  multiplicand, captured with start
in2  input  WIDTH  multiplier, captured with start
busy  output  1  high while an operation is in progress (CALC or FIX)
done  output  1  one-cycle pulse; mul is valid in that cycle
mul  output  2*WIDTH  product, held until the next accepted start's done

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. On rst: state=IDLE, busy=0, done=0, mul=0, counter=0, internal regs=0.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1 (edge E0):
  - capture operands: unsigned mode uses in1/in2 as-is; signed mode uses |in1| and |in2|.
  - store neg = is_signed & (in1[MSB] ^ in2[MSB]).
  - clear the 2*WIDTH-bit accumulator and set counter=WIDTH.
  - go to CALC.
- CALC: each edge adds the shifted multiplicand when the current multiplier LSB is 1. The multiplier shifts right, the multiplicand shifts left, and counter decrements. After exactly WIDTH edges (E1..E_WIDTH), go to FIX.
- FIX (edge E_WIDTH+1):
  - mul <= neg ? two's-complement negation of the accumulator : accumulator.
  - done <= 1 for one cycle.
  - go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH+1 (9 edges after the start edge for WIDTH=8). Throughput is one result per WIDTH+2 cycles.
- busy is 1 for the WIDTH+1 cycles following E0 (CALC and FIX) and 0 in IDLE, including the done cycle.
- start while busy: ignored. No queueing, and operands are not re-captured.
- start in the done cycle: accepted (FSM is in IDLE), giving back-to-back operation. mul keeps the previous result until the new FIX edge.
- Width rules:
  - the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held in WIDTH unsigned bits;
  - the product of magnitudes is at most (2^WIDTH-1)^2, which fits in 2*WIDTH bits;
  - the signed result range is [-2^(2W-2)+2^(W-1), 2^(2W-2)], which fits in 2*WIDTH bits with no overflow.
  - An operand of 0 yields 0 with neg ignored (negated 0 = 0).
- rst asserted mid-operation: abort immediately. No done is produced for the aborted op and mul clears to 0.
- rst and start asserted together: rst wins.
- is_signed=0 with operands whose MSB is set: treated as unsigned, no sign fix.

Decomposition:
- Shared package mul_pkg holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_FIX=2'd2;
  - a function for the WIDTH-bit two's-complement magnitude.
- One sub-module, add_n_bit: a parametrised (N) ripple-carry adder (in1, in2, s), the N-bit successor of the existing 16-bit adder. It is instantiated with N=2*WIDTH for the accumulate step. Negation in FIX reuses the same add_n_bit instance (~acc + 1) muxed onto its inputs.

Test Plan:
- WIDTH=8, unsigned: in1=255, in2=55, start pulse -> done exactly 9 edges after the start edge, mul=16'd14025 (0x36C9), busy high for 9 cycles.
- WIDTH=8, signed: in1=-3 (0xFD), in2=5 -> mul=0xFFF1 (-15); in1=-128 (0x80), in2=-128 -> mul=0x4000 (16384).
- Back-to-back: start 55*55, then assert start with 2*4 in the done cycle -> first done with mul=3025, second done 10 cycles later with mul=8. A start pulse during busy between them is ignored (no extra done).
- Reset mid-op: start 200*200, assert rst at the 4th CALC cycle -> busy=0, done=0, mul=0 next cycle; no done ever appears for that op.
- Zero and sign edge: signed 0*(-1) -> mul=0; unsigned 0xFF*0xFF -> mul=0xFE01.
- WIDTH=16 instance: signed -32768*32767 -> mul=32'hC0008000, done 17 edges after the start edge.
